ips2l_pcie_dma_mwr_sched: RTL and testbench

Memory-write scheduler for the PCIe DMA device-to-host path. It accepts one DMA write command (host address plus length in DWs) and splits it into MWr TLP-sized chunks. Each chunk is sized to respect Max Payload Size and never crosses a 4 KB boundary. Chunks are issued one at a time to the BAR-read/data-FIFO controller (`ips2l_pcie_dma_rd_ctrl`) through its `i_rd_en` / `i_rd_length` / `i_rd_addr` start interface. The scheduler waits for that controller's `o_last_data` before issuing the next chunk.

---
 rtl/pcie_dma_pkg.sv | 9 +
 rtl/ips2l_pcie_dma_chunk_calc.sv | 22 ++
 rtl/ips2l_pcie_dma_mwr_sched.sv | 88 ++++++++
 tb/tb_ips2l_pcie_dma_mwr_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared state encoding and size constants for the PCIe DMA schedulers
package pcie_dma_pkg;
  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_LAST, DONE} sched_state_t;
  localparam logic [2:0] MPS_128 = 3'd0;
  localparam logic [2:0] MPS_256 = 3'd1;
  localparam logic [2:0] MPS_512 = 3'd2;
  localparam int DW_PER_4K = 1024;
  localparam int MAX_CHUNK_DW = 128;
endpackage

// File: rtl/ips2l_pcie_dma_chunk_calc.sv
// ips2l_pcie_dma_chunk_calc: chunk length = min(remaining DW, payload-size DW, DW left to the 4 KB boundary)
module ips2l_pcie_dma_chunk_calc
  import pcie_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic [LEN_WIDTH-1:0] rem,
  input  logic [2:0]           size_code,
  input  logic [9:0]           dw_offset,
  output logic [7:0]           len
);
  localparam int W = LEN_WIDTH > 11 ? LEN_WIDTH : 11;
  logic [W-1:0] rem_w, size_dw, dist4k, m_a, m_b;
  always_comb begin
    rem_w = W'(rem);
    size_dw = (size_code >= MPS_512) ? W'(MAX_CHUNK_DW) : W'(32) << size_code;
    dist4k = W'(DW_PER_4K) - W'(dw_offset);
    m_a = rem_w < size_dw ? rem_w : size_dw;
    m_b = m_a < dist4k ? m_a : dist4k;
    len = 8'(m_b);
  end
endmodule

// File: rtl/ips2l_pcie_dma_mwr_sched.sv
// ips2l_pcie_dma_mwr_sched: splits a DMA write command into MWr-sized chunks and hands them
// one at a time to the rd controller, waiting for its last-beat pulse between chunks.
module ips2l_pcie_dma_mwr_sched
  import pcie_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [63:0]          i_cmd_addr,
  input  logic [LEN_WIDTH-1:0] i_cmd_length,
  input  logic [2:0]           i_cfg_mps,
  input  logic                 i_abort,
  output logic                 o_rd_en,
  output logic [63:0]          o_rd_addr,
  output logic [9:0]           o_rd_length,
  input  logic                 i_last_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [15:0]          o_tlp_cnt
);
  sched_state_t state;
  logic [63:0] addr;
  logic [LEN_WIDTH-1:0] rem, rem_nxt;
  logic [7:0] len;
  logic [15:0] tlp_cnt;

  ips2l_pcie_dma_chunk_calc #(.LEN_WIDTH(LEN_WIDTH)) u_calc (
    .rem(rem),
    .size_code(i_cfg_mps),
    .dw_offset(addr[11:2]),
    .len(len)
  );

  assign o_cmd_ready = rst_n && state == IDLE;
  assign o_busy = state != IDLE;
  assign o_tlp_cnt = tlp_cnt;
  assign rem_nxt = rem - LEN_WIDTH'(o_rd_length);

  // Chunk outputs are loaded in CALC so they are already valid during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      o_rd_en <= 1'b0;
      o_rd_addr <= '0;
      o_rd_length <= '0;
      o_done <= 1'b0;
      tlp_cnt <= '0;
    end else begin
      o_done <= 1'b0;
      if (state != IDLE && i_abort) begin
        state <= IDLE;
        o_rd_en <= 1'b0;
        rem <= '0;
      end else begin
        case (state)
          IDLE: if (i_cmd_valid) begin
            addr <= i_cmd_addr & ~64'd3;
            rem <= i_cmd_length;
            state <= i_cmd_length == '0 ? DONE : CALC;
            o_done <= i_cmd_length == '0;
          end
          CALC: begin
            o_rd_en <= 1'b1;
            o_rd_addr <= addr;
            o_rd_length <= {2'b00, len};
            tlp_cnt <= tlp_cnt + 16'd1;
            state <= ISSUE;
          end
          ISSUE: state <= WAIT_LAST;
          WAIT_LAST: if (i_last_data) begin
            o_rd_en <= 1'b0;
            addr <= addr + {52'd0, o_rd_length, 2'b00};
            rem <= rem_nxt;
            state <= rem_nxt == '0 ? DONE : CALC;
            o_done <= rem_nxt == '0;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ips2l_pcie_dma_mwr_sched.sv
// tb_ips2l_pcie_dma_mwr_sched: directed commands with a chunk-level reference model checked every cycle
module tb_ips2l_pcie_dma_mwr_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_cmd_valid = 1'b0, i_abort = 1'b0, i_last_data = 1'b0;
  logic [63:0] i_cmd_addr = '0;
  logic [15:0] i_cmd_length = '0;
  logic [2:0] i_cfg_mps = '0;
  logic o_cmd_ready, o_rd_en, o_busy, o_done;
  logic [63:0] o_rd_addr;
  logic [9:0] o_rd_length;
  logic [15:0] o_tlp_cnt;
  int checks = 0, failures = 0;
  logic [63:0] got_a[$];
  int got_l[$];
  logic [63:0] m_addr = '0, hold_a = '0;
  logic [9:0] hold_l = '0;
  logic [15:0] m_cnt = '0;
  int m_rem = 0, cur_len = 0;
  logic exp_done = 1'b0, prev_en = 1'b0;

  always #5 clk = ~clk;

  ips2l_pcie_dma_mwr_sched #(.LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_length(i_cmd_length), .i_cfg_mps(i_cfg_mps),
    .i_abort(i_abort), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_rd_length(o_rd_length),
    .i_last_data(i_last_data), .o_busy(o_busy), .o_done(o_done), .o_tlp_cnt(o_tlp_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Chunk rule: min(remaining, payload size, distance to next 4 KB page)
  function automatic int exp_chunk(input logic [63:0] a, input int rem, input logic [2:0] mps);
    int m = int'(mps);
    int r = rem;
    int mps_dw, d4k;
    if (m > 2) m = 2;
    mps_dw = 32 << m;
    d4k = (4096 - int'(a % 64'd4096)) / 4;
    if (mps_dw < r) r = mps_dw;
    if (d4k < r) r = d4k;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt = '0;
      m_rem = 0;
      exp_done = 1'b0;
      prev_en = 1'b0;
    end else begin
      chk("done", o_done, exp_done);
      if (o_rd_en && !prev_en) begin
        cur_len = exp_chunk(m_addr, m_rem, i_cfg_mps);
        chk("chunk_addr", o_rd_addr, m_addr);
        chk("chunk_len", o_rd_length, cur_len);
        m_cnt++;
        hold_a = o_rd_addr;
        hold_l = o_rd_length;
      end else if (o_rd_en) begin
        chk("hold_addr", o_rd_addr, hold_a);
        chk("hold_len", o_rd_length, hold_l);
      end
      chk("tlp_cnt", o_tlp_cnt, m_cnt);
      exp_done = 1'b0;
      if (i_cmd_valid && o_cmd_ready) begin
        m_addr = i_cmd_addr & ~64'd3;
        m_rem = int'(i_cmd_length);
        exp_done = i_cmd_length == 16'd0;
      end
      if (i_last_data && o_rd_en && prev_en && !i_abort) begin
        m_addr = m_addr + 64'(cur_len * 4);
        m_rem = m_rem - cur_len;
        exp_done = m_rem == 0;
      end
      if (i_abort && o_busy) begin
        m_rem = 0;
        exp_done = 1'b0;
      end
      prev_en = o_rd_en;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [63:0] a, input int l);
    chk("cmd_ready", o_cmd_ready, 1);
    i_cmd_addr = a;
    i_cmd_length = l[15:0];
    i_cmd_valid = 1'b1;
    tick;
    i_cmd_valid = 1'b0;
    chk("hs_busy", o_busy, 1);
    chk("hs_en_low", o_rd_en, 0);
    if (l != 0) begin
      tick;
      chk("hs_en_t2", o_rd_en, 1);
    end
  endtask

  // Acts as the rd controller: pulses last_data once the chunk has been up for lat cycles.
  task automatic serve(input int lat, input int sw, input logic [2:0] nm);
    int chunk = 0, hi = 0;
    bit fin = 0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (o_rd_en) begin
        if (hi == 0) begin
          got_a.push_back(o_rd_addr);
          got_l.push_back(int'(o_rd_length));
        end
        hi++;
        if (hi == 2 && chunk == sw) i_cfg_mps = nm;
      end
      if (hi == lat) begin
        i_last_data = 1'b1;
        tick;
        i_last_data = 1'b0;
        hi = 0;
        chunk++;
        chk("gap_low", o_rd_en, 0);
        if (o_done) begin
          tick;
          chk("ready_after_done", o_cmd_ready, 1);
          fin = 1;
        end else begin
          tick;
          chk("gap_high", o_rd_en, 1);
        end
      end else tick;
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL serve_timeout: got no done after 2000 cycles, required done");
    end
  endtask

  task automatic exp_chunks(input string t, input int n,
                            input logic [63:0] a0, input logic [63:0] a1,
                            input logic [63:0] a2, input logic [63:0] a3,
                            input int l0, input int l1, input int l2, input int l3);
    logic [63:0] ea[4];
    int el[4];
    ea = '{a0, a1, a2, a3};
    el = '{l0, l1, l2, l3};
    chk({t, "_count"}, got_l.size(), n);
    for (int i = 0; i < n && i < got_l.size(); i++) begin
      chk($sformatf("%s_addr%0d", t, i), got_a[i], ea[i]);
      chk($sformatf("%s_len%0d", t, i), got_l[i], el[i]);
    end
    got_a.delete();
    got_l.delete();
  endtask

  initial begin
    #1;
    chk("rst_ready", o_cmd_ready, 0);
    chk("rst_en", o_rd_en, 0);
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_len", o_rd_length, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_cnt", o_tlp_cnt, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_ready", o_cmd_ready, 1);

    i_cfg_mps = 3'd0;
    send_cmd(64'h1000_0000, 16);
    serve(3, -1, 3'd0);
    exp_chunks("single", 1, 64'h1000_0000, 0, 0, 0, 16, 0, 0, 0);
    chk("single_cnt", o_tlp_cnt, 1);

    send_cmd(64'h0, 100);
    serve(2, -1, 3'd0);
    exp_chunks("split", 4, 64'h0, 64'h80, 64'h100, 64'h180, 32, 32, 32, 4);

    i_cfg_mps = 3'd1;
    send_cmd(64'h0FF0, 64);
    serve(4, -1, 3'd1);
    exp_chunks("cross4k", 2, 64'h0FF0, 64'h1000, 0, 0, 4, 60, 0, 0);

    i_cfg_mps = 3'd2;
    send_cmd(64'h2000, 200);
    serve(2, 0, 3'd0);
    exp_chunks("mps_chg", 4, 64'h2000, 64'h2200, 64'h2280, 64'h2300, 128, 32, 32, 8);

    i_cfg_mps = 3'd7;
    send_cmd(64'h0, 150);
    serve(2, -1, 3'd7);
    exp_chunks("mps7", 2, 64'h0, 64'h200, 0, 0, 128, 22, 0, 0);

    i_cfg_mps = 3'd0;
    send_cmd(64'h103, 3);
    serve(2, -1, 3'd0);
    exp_chunks("unaligned", 1, 64'h100, 0, 0, 0, 3, 0, 0, 0);

    send_cmd(64'h40, 0);
    chk("zero_done", o_done, 1);
    tick;
    chk("zero_ready", o_cmd_ready, 1);
    chk("zero_en", o_rd_en, 0);
    tick;
    chk("zero_done_gone", o_done, 0);

    send_cmd(64'h5000, 64);
    tick;
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    chk("abort_en", o_rd_en, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_ready", o_cmd_ready, 1);
    tick;
    chk("abort_no_done", o_done, 0);
    send_cmd(64'h6000, 8);
    serve(2, -1, 3'd0);
    exp_chunks("after_abort", 1, 64'h6000, 0, 0, 0, 8, 0, 0, 0);

    send_cmd(64'h7000, 32);
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", o_cmd_ready, 0);
    chk("mid_rst_en", o_rd_en, 0);
    chk("mid_rst_addr", o_rd_addr, 0);
    chk("mid_rst_len", o_rd_length, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_cnt", o_tlp_cnt, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("mid_rst_release", o_cmd_ready, 1);
    got_a.delete();
    got_l.delete();

    force dut.tlp_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    tick;
    release dut.tlp_cnt;
    chk("wrap_preload", o_tlp_cnt, 16'hFFFF);
    send_cmd(64'h8000, 4);
    serve(2, -1, 3'd0);
    chk("wrap_cnt", o_tlp_cnt, 0);
    exp_chunks("wrap", 1, 64'h8000, 0, 0, 0, 4, 0, 0, 0);

    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1 ms, required finish");
    $fatal(1, "watchdog");
  end
endmodule
